// File: rtl/bridge_intc.sv
// CPU-to-peripheral bridge with NDEV 16-byte device windows and a local interrupt
// controller window (PEND/MASK/ACK/STAT) that latches synchronised device interrupts.
module bridge_intc #(
    parameter int          NDEV      = 3,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter logic [5:0]  IRQ_EDGE  = 6'b000000,
    parameter logic [5:0]  MASK_RST  = 6'b111111
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          PrAddr,
    input  logic [31:0]          PrWD,
    input  logic                 PrWe,
    output logic [31:0]          PrRD,
    output logic [31:0]          DevAddr,
    output logic [31:0]          DevWD,
    input  logic [32*NDEV-1:0]   DevRD,
    output logic [NDEV-1:0]      DevWe,
    input  logic [5:0]           DevInt,
    output logic [5:0]           HWInt,
    output logic                 BusErr
);
    typedef enum logic [1:0] {
        REG_PEND = 2'd0,
        REG_MASK = 2'd1,
        REG_ACK  = 2'd2,
        REG_STAT = 2'd3
    } reg_sel_e;

    localparam logic [27:0] BASE_WIN = BASE_ADDR[31:4];
    localparam logic [31:0] ERR_HI   = BASE_ADDR + 32'(16 * (NDEV + 1)) + 32'h0000_00FF;

    logic [NDEV-1:0] dev_hit;
    logic            loc_hit;
    reg_sel_e        reg_sel;
    logic            loc_we_mask, loc_we_ack, loc_we_stat;
    logic            in_range, rd_qual, err_set;
    logic [5:0]      ack_bits, edge_set;

    logic [5:0] s1_q, s2_q, s3_q;
    logic [5:0] pend_q, pend_d;
    logic [5:0] mask_q, mask_d;
    logic [5:0] hwint_q;
    logic       buserr_q, buserr_d;

    always_comb begin
        dev_hit = '0;
        for (int i = 0; i < NDEV; i++) begin
            dev_hit[i] = (PrAddr[31:4] == BASE_WIN + 28'(i));
        end
    end

    assign loc_hit = (PrAddr[31:4] == BASE_WIN + 28'(NDEV));
    assign reg_sel = reg_sel_e'(PrAddr[3:2]);

    assign DevAddr = PrAddr;
    assign DevWD   = PrWD;
    assign DevWe   = PrWe ? dev_hit : '0;

    // NOTE: every signal driven here gets a default first, so no path can hold a stale value and infer a latch.
    always_comb begin
        PrRD = 32'h0000_0000;
        for (int i = 0; i < NDEV; i++) begin
            if (dev_hit[i]) PrRD = DevRD[32*i +: 32];
        end
        if (loc_hit) begin
            case (reg_sel)
                REG_PEND: PrRD = {26'd0, pend_q};
                REG_MASK: PrRD = {26'd0, mask_q};
                REG_ACK:  PrRD = 32'h0000_0000;
                REG_STAT: PrRD = {31'd0, buserr_q};
            endcase
        end
    end

    assign loc_we_mask = PrWe & loc_hit & (reg_sel == REG_MASK);
    assign loc_we_ack  = PrWe & loc_hit & (reg_sel == REG_ACK);
    assign loc_we_stat = PrWe & loc_hit & (reg_sel == REG_STAT);
    assign ack_bits    = loc_we_ack ? PrWD[5:0] : 6'd0;

    // Edge lines: a new edge beats a same-cycle ACK. Level lines: ACK wins for one
    // cycle, then the still-high source re-sets the bit.
    assign edge_set = s2_q & ~s3_q;
    assign pend_d   = (IRQ_EDGE & (edge_set | (pend_q & ~ack_bits)))
                    | (~IRQ_EDGE & ~ack_bits & (s2_q | pend_q));
    assign mask_d   = loc_we_mask ? PrWD[5:0] : mask_q;

    assign in_range = (PrAddr >= BASE_ADDR) && (PrAddr <= ERR_HI);
    assign rd_qual  = (PrAddr[31:8] == BASE_ADDR[31:8]);
    assign err_set  = in_range & (PrWe | rd_qual) & ~(|dev_hit) & ~loc_hit;
    assign buserr_d = err_set | (buserr_q & ~loc_we_stat);

    // NOTE: state uses non-blocking assignments so each flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            pend_q   <= '0;
            mask_q   <= MASK_RST;
            hwint_q  <= '0;
            buserr_q <= 1'b0;
        end else begin
            s1_q     <= DevInt;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            hwint_q  <= pend_q & mask_q;
            buserr_q <= buserr_d;
        end
    end

    assign HWInt  = hwint_q;
    assign BusErr = buserr_q;

endmodule

// File: tb/tb_bridge_intc.sv
// Self-checking bench for bridge_intc: directed scenarios plus randomized traffic
// compared against an address-map / interrupt-history reference model.
`timescale 1ns/1ps
module tb_bridge_intc;
    localparam int          NDEV       = 3;
    localparam logic [31:0] BASE       = 32'h0000_7F00;
    localparam logic [5:0]  EDGE_LINES = 6'b000010;
    localparam logic [31:0] LOC        = BASE + 32'(16 * NDEV);
    localparam logic [31:0] ERR_HI     = BASE + 32'(16 * (NDEV + 1)) + 32'h0000_00FF;
    localparam int          HLEN       = 8192;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [31:0]         PrAddr, PrWD, PrRD, DevAddr, DevWD;
    logic                PrWe, BusErr;
    logic [32*NDEV-1:0]  DevRD;
    logic [NDEV-1:0]     DevWe;
    logic [5:0]          DevInt, HWInt;

    bridge_intc #(
        .NDEV(NDEV), .BASE_ADDR(BASE), .IRQ_EDGE(EDGE_LINES), .MASK_RST(6'h3F)
    ) dut (
        .clk(clk), .reset_n(reset_n), .PrAddr(PrAddr), .PrWD(PrWD), .PrWe(PrWe),
        .PrRD(PrRD), .DevAddr(DevAddr), .DevWD(DevWD), .DevRD(DevRD), .DevWe(DevWe),
        .DevInt(DevInt), .HWInt(HWInt), .BusErr(BusErr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural registers plus the history of sampled DevInt values.
    logic [5:0] m_pend, m_mask, m_hw;
    logic       m_err;
    logic [5:0] din [HLEN];
    int         cyc_n = 0;
    int         first_edge = 32'h3FFF_FFFF;

    function automatic int win_of(input logic [31:0] a);
        if (a >= BASE && a < BASE + 32'(16 * (NDEV + 1))) return int'((a - BASE) >> 4);
        return -1;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        int w;
        w = win_of(a);
        if (w < 0) return 32'd0;
        if (w < NDEV) return DevRD[32*w +: 32];
        case (a[3:2])
            2'd0:    return {26'd0, m_pend};
            2'd1:    return {26'd0, m_mask};
            2'd2:    return 32'd0;
            default: return {31'd0, m_err};
        endcase
    endfunction

    function automatic logic [NDEV-1:0] exp_we(input logic [31:0] a, input logic we);
        logic [NDEV-1:0] r;
        int w;
        r = '0;
        w = win_of(a);
        if (we && w >= 0 && w < NDEV) r[w] = 1'b1;
        return r;
    endfunction

    function automatic logic [5:0] hist(input int k);
        if (k < first_edge || k < 0) return 6'd0;
        return din[k % HLEN];
    endfunction

    task automatic model_reset();
        m_pend = 6'd0;
        m_mask = 6'h3F;
        m_hw   = 6'd0;
        m_err  = 1'b0;
        first_edge = 32'h3FFF_FFFF;
    endtask

    // One clock edge; the model consumes the inputs the bench is driving at that edge.
    task automatic tick();
        logic [5:0] s2, s3, ack, np;
        logic       errset, loc_wr;
        int         w;
        @(posedge clk);
        cyc_n++;
        din[cyc_n % HLEN] = DevInt;
        if (reset_n) begin
            s2 = hist(cyc_n - 2);
            s3 = hist(cyc_n - 3);
            w = win_of(PrAddr);
            loc_wr = PrWe && (w == NDEV);
            ack = (loc_wr && PrAddr[3:2] == 2'd2) ? PrWD[5:0] : 6'd0;
            for (int k = 0; k < 6; k++) begin
                if (EDGE_LINES[k]) np[k] = (s2[k] && !s3[k]) || (m_pend[k] && !ack[k]);
                else               np[k] = !ack[k] && (s2[k] || m_pend[k]);
            end
            errset = (PrAddr >= BASE) && (PrAddr <= ERR_HI)
                   && (PrWe || PrAddr[31:8] == BASE[31:8]) && (w < 0);
            m_hw  = m_pend & m_mask;
            if (loc_wr && PrAddr[3:2] == 2'd1) m_mask = PrWD[5:0];
            m_err  = errset || (m_err && !(loc_wr && PrAddr[3:2] == 2'd3));
            m_pend = np;
        end
        #1;
    endtask

    task automatic idle();
        PrAddr = 32'd0;
        PrWD   = 32'd0;
        PrWe   = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        PrAddr = a;
        PrWD   = d;
        PrWe   = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        checks++; if (HWInt !== 6'd0) begin errors++; $display("FAIL reset_hwint: got %h want 00", HWInt); end
        checks++; if (BusErr !== 1'b0) begin errors++; $display("FAIL reset_buserr: got %b want 0", BusErr); end
        PrAddr = LOC; #1;
        checks++; if (PrRD !== 32'd0) begin errors++; $display("FAIL reset_pend: got %h want 0", PrRD); end
        PrAddr = LOC + 4; #1;
        checks++; if (PrRD !== 32'h3F) begin errors++; $display("FAIL reset_mask: got %h want 3f", PrRD); end
        idle();
    endtask

    task automatic test_decode();
        DevRD = {$urandom, $urandom, $urandom};
        PrAddr = 32'h0000_7F14; PrWD = 32'hA5A5_0001; PrWe = 1'b1; #1;
        checks++; if (DevWe !== 3'b010) begin errors++; $display("FAIL decode_we: got %b want 010", DevWe); end
        checks++; if (DevWD !== 32'hA5A5_0001) begin errors++; $display("FAIL decode_wd: got %h want a5a50001", DevWD); end
        checks++; if (DevAddr !== 32'h0000_7F14) begin errors++; $display("FAIL decode_addr: got %h want 7f14", DevAddr); end
        tick();
        PrWe = 1'b0; PrAddr = 32'h0000_7F24; #1;
        checks++; if (PrRD !== DevRD[95:64]) begin errors++; $display("FAIL decode_rd2: got %h want %h", PrRD, DevRD[95:64]); end
        PrAddr = 32'h0000_7F07; #1;
        checks++; if (PrRD !== DevRD[31:0]) begin errors++; $display("FAIL decode_misaligned: got %h want %h", PrRD, DevRD[31:0]); end
        PrAddr = 32'h0001_7F14; PrWe = 1'b1; #1;
        checks++; if (DevWe !== 3'b000 || PrRD !== 32'd0) begin
            errors++; $display("FAIL decode_alias: got we=%b rd=%h want 000/0", DevWe, PrRD);
        end
        idle();
        tick();
    endtask

    task automatic test_level_irq();
        DevInt = 6'b000001;
        for (int e = 1; e <= 4; e++) begin
            tick();
            if (e == 3) begin
                checks++; if (HWInt[0] !== 1'b0) begin errors++; $display("FAIL level_early: got %b want 0", HWInt[0]); end
            end
        end
        checks++; if (HWInt !== 6'h01) begin errors++; $display("FAIL level_latency: got %h want 01", HWInt); end
        store(LOC + 8, 32'h1);
        PrAddr = LOC; #1;
        checks++; if (PrRD !== 32'd0 || HWInt !== 6'h01) begin
            errors++; $display("FAIL level_ack: got pend=%h hw=%h want 0/01", PrRD, HWInt);
        end
        tick(); #0;
        checks++; if (PrRD !== 32'h1 || HWInt !== 6'h00) begin
            errors++; $display("FAIL level_reset_bit: got pend=%h hw=%h want 1/00", PrRD, HWInt);
        end
        tick();
        checks++; if (HWInt !== 6'h01) begin errors++; $display("FAIL level_reassert: got %h want 01", HWInt); end
        idle(); DevInt = 6'd0;
        repeat (3) tick();
        checks++; if (HWInt !== 6'h01) begin errors++; $display("FAIL level_held: got %h want 01", HWInt); end
        store(LOC + 8, 32'h1);
        PrAddr = LOC; #1;
        checks++; if (PrRD !== 32'd0) begin errors++; $display("FAIL level_clear: got %h want 0", PrRD); end
        tick();
        checks++; if (HWInt !== 6'h00) begin errors++; $display("FAIL level_hw_off: got %h want 00", HWInt); end
        idle();
    endtask

    task automatic test_edge_irq();
        PrAddr = LOC;
        DevInt = 6'b000010; tick();
        DevInt = 6'd0;      tick(); #0;
        checks++; if (PrRD !== 32'd0) begin errors++; $display("FAIL edge_early: got %h want 0", PrRD); end
        tick();
        checks++; if (PrRD !== 32'h2) begin errors++; $display("FAIL edge_latch: got %h want 2", PrRD); end
        DevInt = 6'b000010; tick();
        DevInt = 6'd0;      tick();
        store(LOC + 8, 32'h2);
        PrAddr = LOC; #1;
        checks++; if (PrRD !== 32'h2) begin errors++; $display("FAIL edge_set_wins: got %h want 2", PrRD); end
        store(LOC + 8, 32'h2);
        PrAddr = LOC; #1;
        checks++; if (PrRD !== 32'd0) begin errors++; $display("FAIL edge_ack: got %h want 0", PrRD); end
        idle();
        tick();
    endtask

    task automatic test_mask();
        store(LOC + 4, 32'h0);
        DevInt = 6'b000100;
        repeat (5) tick();
        PrAddr = LOC; #1;
        checks++; if (PrRD !== 32'h4 || HWInt !== 6'h00) begin
            errors++; $display("FAIL mask_off: got pend=%h hw=%h want 4/00", PrRD, HWInt);
        end
        store(LOC + 4, 32'h4);
        checks++; if (HWInt !== 6'h00) begin errors++; $display("FAIL mask_first_edge: got %h want 00", HWInt); end
        tick();
        checks++; if (HWInt !== 6'h04) begin errors++; $display("FAIL mask_second_edge: got %h want 04", HWInt); end
        DevInt = 6'd0;
        repeat (3) tick();
        store(LOC + 8, 32'h3F);
        store(LOC + 4, 32'h3F);
    endtask

    task automatic test_bus_error();
        logic [31:0] ta [8] = '{32'h7F50, 32'h8000, 32'h8030, 32'h803F, 32'h8040, 32'h7EFC, 32'h7F2C, 32'h7F40};
        logic        tw [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        te [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        PrAddr = 32'h0000_7F80; PrWD = $urandom; PrWe = 1'b1; #1;
        checks++; if (DevWe !== 3'b000) begin errors++; $display("FAIL buserr_we: got %b want 000", DevWe); end
        tick(); idle();
        checks++; if (BusErr !== 1'b1) begin errors++; $display("FAIL buserr_set: got %b want 1", BusErr); end
        PrAddr = LOC + 12; #1;
        checks++; if (PrRD !== 32'h1) begin errors++; $display("FAIL buserr_stat: got %h want 1", PrRD); end
        store(LOC + 12, $urandom);
        checks++; if (BusErr !== 1'b0) begin errors++; $display("FAIL buserr_clear: got %b want 0", BusErr); end
        for (int i = 0; i < 8; i++) begin
            PrAddr = ta[i]; PrWD = $urandom; PrWe = tw[i];
            tick(); idle();
            checks++; if (BusErr !== te[i]) begin
                errors++; $display("FAIL buserr_range[%h we=%b]: got %b want %b", ta[i], tw[i], BusErr, te[i]);
            end
            store(LOC + 12, 32'h0);
        end
    endtask

    task automatic test_random();
        int sel;
        for (int n = 0; n < 1500; n++) begin
            DevRD = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) DevInt = DevInt ^ 6'($urandom);
            sel = $urandom_range(0, 9);
            if (sel <= 3)      PrAddr = BASE + 32'($urandom_range(0, 16 * NDEV - 1));
            else if (sel <= 6) PrAddr = LOC + 32'($urandom_range(0, 15));
            else if (sel <= 8) PrAddr = LOC + 32'd16 + 32'($urandom_range(0, 16'h110));
            else               PrAddr = $urandom;
            PrWD = $urandom;
            PrWe = ($urandom_range(0, 2) == 0);
            #1;
            checks++; if (PrRD !== exp_rd(PrAddr) || DevWe !== exp_we(PrAddr, PrWe)) begin
                errors++; $display("FAIL rand_comb @%h we=%b: got rd=%h dwe=%b want rd=%h dwe=%b",
                                   PrAddr, PrWe, PrRD, DevWe, exp_rd(PrAddr), exp_we(PrAddr, PrWe));
            end
            tick();
            checks++; if (HWInt !== m_hw || BusErr !== m_err) begin
                errors++; $display("FAIL rand_state cyc %0d: got hw=%h err=%b want hw=%h err=%b",
                                   cyc_n, HWInt, BusErr, m_hw, m_err);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        DevInt = 6'd0;
        repeat (4) tick();
        store(LOC + 4, 32'h0F);
        DevInt = 6'h3F;
        repeat (5) tick();
        PrAddr = LOC; #1;
        checks++; if (PrRD !== 32'h3F || HWInt !== 6'h0F) begin
            errors++; $display("FAIL midrst_pre: got pend=%h hw=%h want 3f/0f", PrRD, HWInt);
        end
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        checks++; if (HWInt !== 6'h00 || PrRD !== 32'd0 || BusErr !== 1'b0) begin
            errors++; $display("FAIL midrst_async: got hw=%h pend=%h err=%b want 00/0/0", HWInt, PrRD, BusErr);
        end
        PrAddr = LOC + 4; #1;
        checks++; if (PrRD !== 32'h3F) begin errors++; $display("FAIL midrst_mask: got %h want 3f", PrRD); end
        #1 reset_n = 1'b1;
        first_edge = cyc_n + 1;
        idle();
        for (int e = 1; e <= 5; e++) begin
            tick();
            checks++; if (HWInt !== m_hw) begin
                errors++; $display("FAIL midrst_after[%0d]: got %h want %h", e, HWInt, m_hw);
            end
        end
        PrAddr = LOC; #1;
        checks++; if (PrRD !== 32'h3F) begin errors++; $display("FAIL midrst_repend: got %h want 3f", PrRD); end
        idle();
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        DevInt = 6'd0;
        DevRD  = '0;
        model_reset();
        #17 reset_n = 1'b1;
        first_edge = cyc_n + 1;
        test_reset();
        tick();
        test_decode();
        test_level_irq();
        test_edge_irq();
        test_mask();
        test_bus_error();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

endmodule
